// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit scheduler
package uart_pkg;

  localparam int BYTE_W       = 8;
  localparam int NREQ_DEFAULT = 4;
  localparam int OWNER_W      = 3;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin winner search with the last-owner pointer
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic               upd_en,
  input  logic [OWNER_W-1:0] upd_owner,
  output logic               grant_valid,
  output logic [OWNER_W-1:0] grant_idx
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [OWNER_W-1:0] last_owner_q, last_owner_d;
  logic [IW-1:0]      idx;

  // Walk from farthest to nearest so the nearest requester after the pointer wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(last_owner_q) + k) % NREQ);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = OWNER_W'(idx);
      end
    end
  end

  always_comb begin
    last_owner_d = last_owner_q;
    if (upd_en) begin
      last_owner_d = upd_owner;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_owner_q <= OWNER_W'(NREQ - 1);
    end else begin
      last_owner_q <= last_owner_d;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - shares one UART transmitter among NREQ requesters
// Optional watchdog enabled by macro UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NREQ           = NREQ_DEFAULT,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [BYTE_W*NREQ-1:0] req_data,
  input  logic                   tx_ready,
  input  logic                   err_clr,
  output logic [NREQ-1:0]        ack,
  output logic                   tx_load,
  output logic [BYTE_W-1:0]      tx_data,
  output logic [2:0]             owner,
  output logic                   busy,
  output logic                   timeout_err
);

  state_e             state_q, state_d;
  logic [NREQ-1:0]    ack_q, ack_d;
  logic               tx_load_q, tx_load_d;
  logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic               grant_valid;
  logic [OWNER_W-1:0] grant_idx;
  logic               upd_en;
  logic               timeout_hit;
  logic               timeout_fire;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .upd_en      (upd_en),
    .upd_owner   (owner_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    state_d      = state_q;
    ack_d        = '0;
    tx_load_d    = 1'b0;
    tx_data_d    = tx_data_q;
    owner_d      = owner_q;
    upd_en       = 1'b0;
    timeout_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_ready && grant_valid) begin
          state_d   = LOAD;
          ack_d     = NREQ'(1) << grant_idx;
          tx_load_d = 1'b1;
          tx_data_d = req_data[BYTE_W*grant_idx +: BYTE_W];
          owner_d   = grant_idx;
        end
      end
      LOAD: state_d = WAIT_BUSY;
      // A real handshake edge takes priority over a watchdog expiry in the same cycle.
      WAIT_BUSY: begin
        if (!tx_ready) begin
          state_d = WAIT_DONE;
        end else if (timeout_hit) begin
          state_d      = IDLE;
          upd_en       = 1'b1;
          timeout_fire = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          state_d = IDLE;
          upd_en  = 1'b1;
        end else if (timeout_hit) begin
          state_d      = IDLE;
          upd_en       = 1'b1;
          timeout_fire = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ack_q     <= '0;
      tx_load_q <= 1'b0;
      tx_data_q <= '0;
      owner_q   <= '0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      tx_load_q <= tx_load_d;
      tx_data_q <= tx_data_d;
      owner_q   <= owner_d;
    end
  end

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             waiting;

  assign waiting     = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
  assign timeout_hit = waiting && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter restarts whenever a wait state is (re-)entered.
  always_comb begin
    cnt_d = '0;
    if (waiting && (state_d == state_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    err_d = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (timeout_fire) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  logic unused_cfg;

  assign timeout_hit = 1'b0;
  assign unused_cfg  = err_clr | timeout_fire | (TIMEOUT_CYCLES == 0);
  assign timeout_err = 1'b0;
`endif

  assign ack     = ack_q;
  assign tx_load = tx_load_q;
  assign tx_data = tx_data_q;
  assign owner   = owner_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed vector bench for uart_tx_sched
module tb_uart_tx_sched;

  localparam int NREQ = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [NREQ-1:0]  req = '0;
  logic [8*NREQ-1:0] req_data = 32'h7FC3_51AE;
  logic             tx_ready = 1'b1;
  logic             err_clr = 1'b0;
  logic [NREQ-1:0]  ack;
  logic             tx_load;
  logic [7:0]       tx_data;
  logic [2:0]       owner;
  logic             busy;
  logic             timeout_err;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  uart_tx_sched #(.NREQ(NREQ), .TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .tx_ready    (tx_ready),
    .err_clr     (err_clr),
    .ack         (ack),
    .tx_load     (tx_load),
    .tx_data     (tx_data),
    .owner       (owner),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  typedef struct packed {
    logic [3:0] req;
    logic       rdy;
    logic [3:0] ack;
    logic       load;
    logic [7:0] data;
    logic [2:0] owner;
    logic       busy;
  } vec_t;

  vec_t tbl [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    req      = '0;
    tx_ready = 1'b1;
    err_clr  = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic finish_xfer();
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    step();
    tx_ready = 1'b1;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1);
  end

  initial begin
    int exp_order [5];
    logic found;

    //          req      rdy   ack      ld    data   own   busy
    tbl[0]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 8'hAE, 3'd0, 1'b1};
    tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'hAE, 3'd0, 1'b1};
    tbl[2]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'hAE, 3'd0, 1'b1};
    tbl[3]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'hAE, 3'd0, 1'b1};
    tbl[4]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'hAE, 3'd0, 1'b1};
    tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'hAE, 3'd0, 1'b0};
    tbl[6]  = '{4'b0100, 1'b0, 4'b0000, 1'b0, 8'hAE, 3'd0, 1'b0};
    tbl[7]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 8'hC3, 3'd2, 1'b1};
    tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'hC3, 3'd2, 1'b1};
    tbl[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'hC3, 3'd2, 1'b1};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'hC3, 3'd2, 1'b0};
    tbl[11] = '{4'b1011, 1'b1, 4'b1000, 1'b1, 8'h7F, 3'd3, 1'b1};
    tbl[12] = '{4'b1011, 1'b1, 4'b0000, 1'b0, 8'h7F, 3'd3, 1'b1};
    tbl[13] = '{4'b1011, 1'b0, 4'b0000, 1'b0, 8'h7F, 3'd3, 1'b1};
    tbl[14] = '{4'b0011, 1'b1, 4'b0000, 1'b0, 8'h7F, 3'd3, 1'b0};
    tbl[15] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 8'hAE, 3'd0, 1'b1};
    tbl[16] = '{4'b0010, 1'b1, 4'b0000, 1'b0, 8'hAE, 3'd0, 1'b1};
    tbl[17] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'hAE, 3'd0, 1'b1};
    tbl[18] = '{4'b0010, 1'b1, 4'b0000, 1'b0, 8'hAE, 3'd0, 1'b0};
    tbl[19] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 8'h51, 3'd1, 1'b1};
    tbl[20] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h51, 3'd1, 1'b1};
    tbl[21] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h51, 3'd1, 1'b1};
    tbl[22] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h51, 3'd1, 1'b0};

    step();
    step();
    chk("rst ack", 32'(ack), 32'h0);
    chk("rst tx_load", 32'(tx_load), 32'h0);
    chk("rst tx_data", 32'(tx_data), 32'h0);
    chk("rst owner", 32'(owner), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst timeout_err", 32'(timeout_err), 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 23; i++) begin
      req      = tbl[i].req;
      tx_ready = tbl[i].rdy;
      step();
      chk($sformatf("v%0d ack", i), 32'(ack), 32'(tbl[i].ack));
      chk($sformatf("v%0d tx_load", i), 32'(tx_load), 32'(tbl[i].load));
      chk($sformatf("v%0d tx_data", i), 32'(tx_data), 32'(tbl[i].data));
      chk($sformatf("v%0d owner", i), 32'(owner), 32'(tbl[i].owner));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].busy));
    end

    // Transmitter not ready: no grant for 20 cycles, then immediate grant.
    req      = 4'b0100;
    tx_ready = 1'b0;
    for (int t = 0; t < 20; t++) begin
      step();
      chk($sformatf("notrdy%0d ack", t), 32'(ack), 32'h0);
      chk($sformatf("notrdy%0d tx_load", t), 32'(tx_load), 32'h0);
    end
    tx_ready = 1'b1;
    step();
    chk("notrdy grant ack", 32'(ack), 32'h4);
    chk("notrdy grant tx_data", 32'(tx_data), 32'hC3);
    req = '0;
    finish_xfer();

    // Reset during WAIT_DONE.
    req      = 4'b0001;
    tx_ready = 1'b1;
    step();
    req = '0;
    step();
    tx_ready = 1'b0;
    step();
    chk("midrst busy before", 32'(busy), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("midrst ack", 32'(ack), 32'h0);
    chk("midrst tx_load", 32'(tx_load), 32'h0);
    chk("midrst tx_data", 32'(tx_data), 32'h0);
    chk("midrst owner", 32'(owner), 32'h0);
    chk("midrst busy", 32'(busy), 32'h0);
    tx_ready = 1'b1;
    step();
    chk("midrst held ack", 32'(ack), 32'h0);
    chk("midrst held tx_load", 32'(tx_load), 32'h0);
    reset = 1'b1;
    req   = 4'b0011;
    step();
    chk("postrst ack", 32'(ack), 32'h1);
    chk("postrst owner", 32'(owner), 32'h0);
    req = '0;
    finish_xfer();

    // Round robin with all requests held, transmitter busy 10 cycles per byte.
    do_reset();
    exp_order = '{0, 1, 2, 3, 0};
    req       = 4'b1111;
    tx_ready  = 1'b1;
    for (int g = 0; g < 5; g++) begin
      found = 1'b0;
      for (int t = 0; t < 30 && !found; t++) begin
        step();
        if (ack != 4'b0000) found = 1'b1;
      end
      chk($sformatf("rr%0d grant seen", g), 32'(found), 32'h1);
      chk($sformatf("rr%0d owner", g), 32'(owner), 32'(exp_order[g]));
      chk($sformatf("rr%0d ack", g), 32'(ack), 32'h1 << exp_order[g]);
      chk($sformatf("rr%0d tx_load", g), 32'(tx_load), 32'h1);
      step();
      chk($sformatf("rr%0d ack width", g), 32'(ack), 32'h0);
      chk($sformatf("rr%0d tx_load width", g), 32'(tx_load), 32'h0);
      tx_ready = 1'b0;
      repeat (10) step();
      tx_ready = 1'b1;
    end
    req = '0;
    step();
    chk("rr idle", 32'(busy), 32'h0);

    // Transmitter never drops ready after a grant.
    req = 4'b0001;
    step();
    chk("to grant tx_load", 32'(tx_load), 32'h1);
    req = '0;
    repeat (16) step();
    chk("to wait busy", 32'(busy), 32'h1);
    chk("to wait err", 32'(timeout_err), 32'h0);
    err_clr = 1'b1;
    step();
`ifdef UART_TX_SCHED_TIMEOUT_EN
    chk("to expire busy", 32'(busy), 32'h0);
    chk("to expire err set wins", 32'(timeout_err), 32'h1);
`else
    chk("to noexp busy", 32'(busy), 32'h1);
    chk("to noexp err", 32'(timeout_err), 32'h0);
`endif
    step();
    chk("to err_clr", 32'(timeout_err), 32'h0);
    err_clr = 1'b0;
`ifndef UART_TX_SCHED_TIMEOUT_EN
    repeat (40) step();
    chk("to long wait busy", 32'(busy), 32'h1);
    chk("to long wait err", 32'(timeout_err), 32'h0);
    tx_ready = 1'b0;
    step();
    tx_ready = 1'b1;
    step();
    chk("to done busy", 32'(busy), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
